// File: rtl/core_pkg.sv
// Shared core definitions: opcode encodings used by fetch and the controller,
// the canonical NOP word, and default datapath widths.
package core_pkg;

  localparam int unsigned PC_W_DEF  = 9;
  localparam int unsigned INS_W_DEF = 32;

  // addi x0,x0,0 -- decodes as I-type with rd=x0, so it has no architectural effect
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [6:0] {
    R_TYPE = 7'b0110011,
    I_TYPE = 7'b0010011,
    LW     = 7'b0000011,
    SW     = 7'b0100011,
    BR     = 7'b1100011,
    JAL    = 7'b1101111,
    JALR   = 7'b1100111
  } opcode_e;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register.
// Update priority: reset > squash (bubble) > stall (hold) > !ready (bubble) > load.
// Ports:
//   clk, reset     clock, synchronous active-low reset
//   stall_i        hold all fields
//   squash_i       load a bubble (redirect or flush); overrides stall
//   ready_i        instruction memory data valid this cycle
//   pc_i, instr_i  PC and instruction word to capture
//   pc_o, instr_o, valid_o  registered outputs
module if_id_reg
  import core_pkg::*;
#(
  parameter int unsigned PC_W  = PC_W_DEF,
  parameter int unsigned INS_W = INS_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall_i,
  input  logic             squash_i,
  input  logic             ready_i,
  input  logic [PC_W-1:0]  pc_i,
  input  logic [INS_W-1:0] instr_i,
  output logic [PC_W-1:0]  pc_o,
  output logic [INS_W-1:0] instr_o,
  output logic             valid_o
);

  logic [PC_W-1:0]  pc_q, pc_d;
  logic [INS_W-1:0] instr_q, instr_d;
  logic             valid_q, valid_d;

  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    if (squash_i || (!stall_i && !ready_i)) begin
      pc_d    = '0;
      instr_d = INS_W'(NOP_INSTR);
      valid_d = 1'b0;
    end else if (!stall_i) begin
      pc_d    = pc_i;
      instr_d = instr_i;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q    <= '0;
      instr_q <= INS_W'(NOP_INSTR);
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
    end
  end

  assign pc_o    = pc_q;
  assign instr_o = instr_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, next-PC selection and the IF/ID register.
// Next-PC priority: reset > redirect (word-aligned target) > stall > !ready > PC+4.
// Ports:
//   clk, reset                 clock, synchronous active-low reset
//   stall_i, flush_i           hazard hold / IF/ID squash
//   br_taken_i, br_pc_i        redirect and its target (bits [1:0] dropped)
//   imem_ready_i, imem_data_i  instruction memory response for imem_addr_o
//   imem_addr_o                current PC, straight from the PC flop
//   if_id_pc_o, if_id_instr_o, if_id_valid_o  IF/ID register outputs
// Optional macro FETCH_PERF_CNT_EN adds saturating counters:
//   fetch_cnt_o (valid loads), stall_cnt_o (IF/ID holds), flush_cnt_o (squashes).
module fetch_stage
  import core_pkg::*;
#(
  parameter int unsigned     PC_W     = PC_W_DEF,
  parameter int unsigned     INS_W    = INS_W_DEF,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall_i,
  input  logic             flush_i,
  input  logic             br_taken_i,
  input  logic [PC_W-1:0]  br_pc_i,
  input  logic             imem_ready_i,
  input  logic [INS_W-1:0] imem_data_i,
  output logic [PC_W-1:0]  imem_addr_o,
  output logic [PC_W-1:0]  if_id_pc_o,
  output logic [INS_W-1:0] if_id_instr_o,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0]      fetch_cnt_o,
  output logic [31:0]      stall_cnt_o,
  output logic [31:0]      flush_cnt_o,
`endif
  output logic             if_id_valid_o
);

  logic [PC_W-1:0] pc_q, pc_d;
  logic            squash;

  assign squash = br_taken_i || flush_i;

  always_comb begin
    pc_d = pc_q;
    if (br_taken_i) begin
      pc_d = br_pc_i & ~PC_W'(3);
    end else if (!stall_i && imem_ready_i) begin
      pc_d = pc_q + PC_W'(4);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign imem_addr_o = pc_q;

  if_id_reg #(
    .PC_W  (PC_W),
    .INS_W (INS_W)
  ) u_if_id_reg (
    .clk      (clk),
    .reset    (reset),
    .stall_i  (stall_i),
    .squash_i (squash),
    .ready_i  (imem_ready_i),
    .pc_i     (pc_q),
    .instr_i  (imem_data_i),
    .pc_o     (if_id_pc_o),
    .instr_o  (if_id_instr_o),
    .valid_o  (if_id_valid_o)
  );

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;
  logic        fetch_inc, stall_inc;

  // Mirrors the IF/ID priority so each counter tracks what that register actually did.
  assign fetch_inc = !squash && !stall_i && imem_ready_i;
  assign stall_inc = !squash && stall_i;

  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (fetch_inc && (fetch_cnt_q != '1)) fetch_cnt_d = fetch_cnt_q + 32'd1;
    if (stall_inc && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 32'd1;
    if (squash    && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign fetch_cnt_o = fetch_cnt_q;
  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`endif

endmodule
